// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions: data width, fetch buffer entry and the default reset PC.
package rv32i_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; the head is read straight from storage.
module fetch_fifo
   import rv32i_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         flush_i,
   input  logic         push_i,
   input  fetch_entry_t entry_i,
   input  logic         pop_i,
   output fetch_entry_t entry_o,
   output logic         full_o,
   output logic         empty_o,
   output logic [AW:0]  count_o
);

   fetch_entry_t  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign full_o  = (r_count == (AW+1)'(DEPTH));
   assign empty_o = (r_count == '0);
   assign count_o = r_count;
   assign entry_o = r_mem[r_rptr];

   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign w_pop  = pop_i & ~empty_o;
   assign w_push = push_i & (~full_o | w_pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= '0;
         end
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= entry_i;
         end
         if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited imem requests, response FIFO, redirect with response discard.
// Build option FETCH_MISALIGN_EN: a misaligned redirect stalls fetch and raises misaligned_o.
module fetch_unit
   import rv32i_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int unsigned     FIFO_DEPTH = 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            instr_valid_o,
   input  logic            instr_ready_i,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] pc_o
`ifdef FETCH_MISALIGN_EN
   ,
   output logic            misaligned_o
`endif
);

   localparam int unsigned CW           = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] DEPTH_W      = (CW+1)'(FIFO_DEPTH);
   // Discard plus outstanding must stay representable in a CW-bit counter.
   localparam logic [CW:0] MAX_INFLIGHT = (CW+1)'((2 ** CW) - 1);

   logic            r_run;
   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_rsp_pc;
   logic [CW-1:0]   r_outst;
   logic [CW-1:0]   r_discard;
   logic [CW-1:0]   w_count;
   logic            w_accept;
   logic            w_live_rsp;
   logic            w_drop_rsp;
   logic            w_push;
   logic            w_pop;
   logic            w_credit;
   logic            w_room;
   logic            w_stall;
   logic            w_empty;
   logic            w_unused_full;
   logic [XLEN-1:0] w_target;
   fetch_entry_t    w_push_entry;
   fetch_entry_t    w_head;

`ifdef FETCH_MISALIGN_EN
   logic r_misaligned;

   assign w_target     = redirect_pc_i;
   assign w_stall      = r_misaligned;
   assign misaligned_o = r_misaligned;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_misaligned <= 1'b0;
      end else if (redirect_i) begin
         r_misaligned <= |redirect_pc_i[1:0];
      end
   end
`else
   logic w_unused_pc_lsb;

   assign w_target        = {redirect_pc_i[XLEN-1:2], 2'b00};
   assign w_stall         = 1'b0;
   assign w_unused_pc_lsb = ^redirect_pc_i[1:0];
`endif

   assign w_pop      = instr_valid_o & instr_ready_i;
   // A pop this cycle frees a slot, which is what allows one instruction per cycle.
   assign w_credit   = ({1'b0, w_count} + {1'b0, r_outst}) < (DEPTH_W + (CW+1)'(w_pop));
   assign w_room     = ({1'b0, r_discard} + {1'b0, r_outst}) < MAX_INFLIGHT;
   assign imem_req_o  = r_run & w_credit & w_room & ~w_stall;
   assign imem_addr_o = r_fetch_pc;

   assign w_accept   = imem_req_o & imem_gnt_i;
   assign w_drop_rsp = imem_rvalid_i & (r_discard != '0);
   assign w_live_rsp = imem_rvalid_i & (r_discard == '0);
   assign w_push     = w_live_rsp & ~redirect_i;

   assign w_push_entry.pc    = r_rsp_pc;
   assign w_push_entry.instr = imem_rdata_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_run      <= 1'b0;
         r_fetch_pc <= RESET_PC;
         r_rsp_pc   <= RESET_PC;
         r_outst    <= '0;
         r_discard  <= '0;
      end else begin
         r_run <= 1'b1;
         if (redirect_i) begin
            // Everything still in flight, including a grant this cycle, becomes stale.
            r_fetch_pc <= w_target;
            r_rsp_pc   <= w_target;
            r_outst    <= '0;
            r_discard  <= r_discard + r_outst + CW'(w_accept) - CW'(imem_rvalid_i);
         end else begin
            if (w_accept) r_fetch_pc <= next_pc(r_fetch_pc);
            if (w_push)   r_rsp_pc   <= next_pc(r_rsp_pc);
            r_outst   <= r_outst + CW'(w_accept) - CW'(w_live_rsp);
            r_discard <= r_discard - CW'(w_drop_rsp);
         end
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (redirect_i),
      .push_i  (w_push),
      .entry_i (w_push_entry),
      .pop_i   (w_pop),
      .entry_o (w_head),
      .full_o  (w_unused_full),
      .empty_o (w_empty),
      .count_o (w_count)
   );

   assign instr_valid_o = ~w_empty;
   assign instr_o       = w_head.instr;
   assign pc_o          = w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic against a PC-stream reference model.
module tb_fetch_unit;
   import rv32i_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
`ifdef FETCH_MISALIGN_EN
   logic        misaligned_o;
`endif

   always #5 clk_i = ~clk_i;

   fetch_unit #(
      .RESET_PC   (RESET_PC),
      .FIFO_DEPTH (2)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .instr_valid_o (instr_valid_o),
      .instr_ready_i (instr_ready_i),
      .instr_o       (instr_o),
      .pc_o          (pc_o)
`ifdef FETCH_MISALIGN_EN
      ,
      .misaligned_o  (misaligned_o)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_acc    = 0;
   int n_pop    = 0;
   int n_wrap   = 0;
   int n_req_cyc = 0;
   int first_valid_cyc = 0;

   logic [31:0] exp_fetch;
   logic [31:0] exp_pc;
   logic [31:0] resp_q[$];

   bit gnt_rand, rsp_rand, rsp_hold, ready_rand, ready_level, redir_rand;
   bit force_redir, force_dir, cur_dir;
   logic [31:0] force_pc;
   bit p_req, p_gnt, p_redir, p_dir, p_valid, p_mis;
   logic [31:0] p_addr, p_target;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic drive();
      logic [31:0] t;
      imem_gnt_i = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rsp_hold || resp_q.size() == 0 || (rsp_rand && $urandom_range(0, 2) == 0)) begin
         imem_rvalid_i = 1'b0;
         imem_rdata_i  = $urandom();
      end else begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = mem_word(resp_q.pop_front());
      end
      instr_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : ready_level;
      redirect_i    = 1'b0;
      redirect_pc_i = $urandom();
      cur_dir       = 1'b0;
      if (force_redir) begin
         redirect_i    = 1'b1;
         redirect_pc_i = force_pc;
         cur_dir       = force_dir;
         force_redir   = 1'b0;
      end else if (redir_rand && $urandom_range(0, 15) == 0) begin
         t = $urandom();
         if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
`ifdef FETCH_MISALIGN_EN
         t = t & 32'hFFFF_FFFC;
`endif
         redirect_i    = 1'b1;
         redirect_pc_i = t;
      end
   endtask

   // Reference: granted addresses and delivered PCs each form a +4 stream restarted by redirects.
   task automatic observe();
      logic acc, pop;
      cyc++;
      acc = imem_req_o & imem_gnt_i;
      pop = instr_valid_o & instr_ready_i;
      if (cyc == 1) begin
         chk("first_req", 32'(imem_req_o), 32'd1);
         chk("first_addr", imem_addr_o, RESET_PC);
      end
      if (p_req && !p_gnt && !p_redir && imem_req_o) chk("addr_hold", imem_addr_o, p_addr);
      if (p_redir) chk("flush_valid", 32'(instr_valid_o), 32'd0);
      if (p_redir && p_dir) begin
         chk("redir_req", 32'(imem_req_o), 32'd1);
         chk("redir_addr", imem_addr_o, p_target);
      end
      if (instr_valid_o && first_valid_cyc == 0) first_valid_cyc = cyc;
      if (imem_req_o) n_req_cyc++;
      if (acc) begin
         chk("fetch_addr", imem_addr_o, exp_fetch);
         if (exp_fetch == 32'hFFFF_FFFC) n_wrap++;
         exp_fetch = exp_fetch + 32'd4;
         resp_q.push_back(imem_addr_o);
         n_acc++;
      end
      if (pop) begin
         chk("pc", pc_o, exp_pc);
         chk("instr", instr_o, mem_word(exp_pc));
         exp_pc = exp_pc + 32'd4;
         n_pop++;
      end
      if (redirect_i) begin
         exp_fetch = redirect_pc_i & 32'hFFFF_FFFC;
         exp_pc    = redirect_pc_i & 32'hFFFF_FFFC;
      end
      p_req    = imem_req_o;
      p_gnt    = imem_gnt_i;
      p_redir  = redirect_i;
      p_dir    = cur_dir;
      p_addr   = imem_addr_o;
      p_target = redirect_pc_i & 32'hFFFF_FFFC;
      p_valid  = instr_valid_o;
`ifdef FETCH_MISALIGN_EN
      p_mis    = misaligned_o;
`else
      p_mis    = 1'b0;
`endif
   endtask

   task automatic tick();
      drive();
      @(negedge clk_i);
      observe();
      @(posedge clk_i);
      #1;
   endtask

   task automatic redirect_to(input logic [31:0] pc, input bit dir);
      force_redir = 1'b1;
      force_pc    = pc;
      force_dir   = dir;
      tick();
   endtask

   task automatic wait_valid_pc(input string tag, input logic [31:0] pc);
      int n;
      n = 0;
      while (n < 50) begin
         tick();
         if (p_valid) break;
         n++;
      end
      if (n >= 50) chk({tag, "_timeout"}, 32'd0, 32'd1);
      else chk(tag, pc_o, pc);
   endtask

   initial begin
      int a0, p0;
      gnt_rand = 0; rsp_rand = 0; rsp_hold = 0; ready_rand = 0; ready_level = 1; redir_rand = 0;
      force_redir = 0; force_dir = 0; force_pc = '0; cur_dir = 0;
      p_req = 0; p_gnt = 0; p_redir = 0; p_dir = 0; p_valid = 0; p_mis = 0;
      p_addr = '0; p_target = '0;
      rst_ni = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      redirect_i = 1'b0; redirect_pc_i = '0; instr_ready_i = 1'b0;
      exp_fetch = RESET_PC;
      exp_pc    = RESET_PC;

      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_req", 32'(imem_req_o), 32'd0);
      chk("rst_addr", imem_addr_o, RESET_PC);
      chk("rst_valid", 32'(instr_valid_o), 32'd0);
      chk("rst_instr", instr_o, 32'd0);
      chk("rst_pc", pc_o, 32'd0);
`ifdef FETCH_MISALIGN_EN
      chk("rst_mis", 32'(misaligned_o), 32'd0);
`endif
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      // Single-cycle memory, decoder always ready.
      repeat (15) tick();
      chk("first_valid_cyc", first_valid_cyc, 32'd3);
      chk("throughput", n_pop, 32'd13);

      // Decoder stalls: fetch must stop once the buffer is committed.
      ready_level = 0;
      a0 = n_acc;
      repeat (10) tick();
      chk("stall_grants_le2", 32'(n_acc - a0 <= 2), 32'd1);
      chk("stall_req", 32'(p_req), 32'd0);
      chk("stall_valid", 32'(p_valid), 32'd1);
      ready_level = 1;
      p0 = n_pop;
      repeat (6) tick();
      chk("resume_pops", n_pop - p0, 32'd6);

      // Two responses held in flight across a redirect.
      rsp_hold = 1;
      repeat (4) tick();
      chk("held_inflight", resp_q.size(), 32'd2);
      redirect_to(32'h0000_0100, 1'b1);
      rsp_hold = 0;
      ready_level = 0;
      wait_valid_pc("redir_pc_100", 32'h0000_0100);
      chk("redir_instr_100", instr_o, mem_word(32'h0000_0100));
      ready_level = 1;

      // Redirect in a cycle that also grants and pops.
      repeat (6) tick();
      chk("pre_redir_valid", 32'(p_valid), 32'd1);
      redirect_to(32'h0000_0300, 1'b1);
      ready_level = 0;
      wait_valid_pc("redir_pc_300", 32'h0000_0300);
      ready_level = 1;

      // Fetch PC wrap.
      redirect_to(32'hFFFF_FFF8, 1'b1);
      repeat (10) tick();
      chk("wrap_seen", 32'(n_wrap > 0), 32'd1);

`ifdef FETCH_MISALIGN_EN
      repeat (4) tick();
      redirect_to(32'h0000_0102, 1'b0);
      a0 = n_req_cyc;
      tick();
      chk("mis_set", 32'(p_mis), 32'd1);
      repeat (6) tick();
      chk("mis_no_req", n_req_cyc - a0, 32'd0);
      chk("mis_hold", 32'(p_mis), 32'd1);
      redirect_to(32'h0000_0200, 1'b1);
      tick();
      chk("mis_clear", 32'(p_mis), 32'd0);
      ready_level = 0;
      wait_valid_pc("mis_resume_pc", 32'h0000_0200);
      ready_level = 1;
`endif

      // Random traffic.
      gnt_rand = 1; rsp_rand = 1; ready_rand = 1; redir_rand = 1;
      repeat (3000) tick();
      gnt_rand = 0; rsp_rand = 0; ready_rand = 0; redir_rand = 0; ready_level = 1;
      p0 = n_pop;
      repeat (20) tick();
      chk("drain_live", 32'(n_pop - p0 > 10), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the rv32i core, directly upstream of the decoder. Keeps the fetch PC, issues word requests to instruction memory over a request/grant/response bus, and buffers returned words with their PCs in a small FIFO. Presents instructions to the decoder with a valid/ready handshake. Redirects from execute flush the FIFO and discard any responses still in flight.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; must be word-aligned.
- `FIFO_DEPTH`, default 2: buffer entries; power of two, ≥ 2.

- `clk_i` input 1: core clock.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `imem_req_o` output 1: fetch request.
- `imem_addr_o` output 32: fetch address (fetch PC).
- `imem_gnt_i` input 1: request accepted this cycle.
- `imem_rvalid_i` input 1: response valid; responses return in order, at least 1 cycle after grant.
- `imem_rdata_i` input 32: response word.
- `redirect_i` input 1: pipeline redirect (branch/jump taken).
- `redirect_pc_i` input 32: redirect target.
- `instr_valid_o` output 1: FIFO head valid.
- `instr_ready_i` input 1: decoder accepts head.
- `instr_o` output 32: head instruction word, to decoder `instruction_i`.
- `pc_o` output 32: head PC.
- `misaligned_o` output 1: present only with `FETCH_MISALIGN_EN`.

## Operation
- Credit rule: `imem_req_o` = 1 when occupancy + outstanding < `FIFO_DEPTH` and not stalled. Responses are never back-pressured and never overflow the FIFO.
- A request is accepted on `imem_req_o & imem_gnt_i`. Outstanding count goes up by 1 and fetch PC advances by 4. The PC wraps modulo 2^32: 32'hFFFF_FFFC goes to 0.
- The request holds its address until granted; `imem_addr_o` is stable while `imem_req_o` is high and not granted.
- Response: push {PC of oldest outstanding request, rdata} and decrement outstanding. Response PCs come from a per-request PC queue, or equivalently from a response PC register advanced by 4 per accepted response.
- Pop on `instr_valid_o & instr_ready_i`. Push and pop in the same cycle keeps occupancy unchanged, including when the FIFO is full.
- Redirect (cycle R):
  - FIFO flushed. A pop in cycle R still completes.
  - Fetch PC ← `redirect_pc_i`.
  - Discard counter ← outstanding + (grant in R) − (rvalid in R). The R-cycle grant is stale.
  - While the discard counter is non-zero, each rvalid decrements it and is not pushed.
- Redirect while discarding: the counter is reloaded by the same rule, so it accumulates correctly.
- Occupancy, outstanding, and discard counters are `$clog2(FIFO_DEPTH)+1` bits wide.

## Timing
- Reset values:
  - `imem_req_o`=0, `imem_addr_o`=`RESET_PC`.
  - `instr_valid_o`=0, `instr_o`=0, `pc_o`=0.
  - All counters 0; `misaligned_o`=0.
- First request in the first cycle after `rst_ni` deasserts.
- Latency: grant in cycle N, rvalid in N+1, `instr_valid_o` in N+2 (FIFO output registered, no bypass).
- Redirect in R: `instr_valid_o`=0 in R+1; request to target issued in R+1.
- Reset asserted mid-operation: all state cleared asynchronously; in-flight responses after reset are not expected.
- Back-to-back throughput of 1 instr/cycle requires single-cycle memory and `FIFO_DEPTH` ≥ 2.

## Configuration
- `FETCH_MISALIGN_EN` defined:
  - A redirect with `redirect_pc_i[1:0]` ≠ 0 stalls fetch (no requests).
  - `misaligned_o` goes to 1 in R+1 and holds until the next aligned redirect.
  - Discards still complete.
- Undefined: `redirect_pc_i[1:0]` is forced to 2'b00; the `misaligned_o` port and the stall logic do not exist.

## Structure
- Shared package `rv32i_pkg`: `XLEN`, `fetch_entry_t` {pc, instr}, default `RESET_PC` constant.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t` with flush, push, pop, full, empty, and count outputs.

## Test plan
- Reset release, memory always grants with 1-cycle rvalid, ready=1 → PCs 0,4,8,… on `pc_o` each cycle from cycle 3; `instr_o` matches memory.
- Ready=0 for 10 cycles → `imem_req_o` drops after 2 grants; no data lost; PCs resume in order on ready.
- Redirect to 32'h100 with 2 responses outstanding → those 2 are discarded; next `pc_o` is 32'h100.
- Redirect coincident with grant and a pop → popped instruction accepted, granted response discarded, fetch restarts at target.
- Fetch PC at 32'hFFFF_FFFC → next address 0.
- With `FETCH_MISALIGN_EN`: redirect to 32'h102 → `misaligned_o`=1, no requests; aligned redirect to 32'h200 clears it and resumes.
